// File: rtl/avr_xmem_bridge_pkg.sv
// Shared definitions for the AVR external-memory bridge: FSM states,
// bus constants and small byte-lane helpers.
package avr_xmem_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [3:0] BE_ALL    = 4'hF;
    localparam logic [7:0] ERR_RDATA = 8'hFF;

    // Pick byte `lane` out of a 32-bit little-endian word.
    function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] lane);
        return w[{lane, 3'b000} +: 8];
    endfunction

    // One-hot byte enable for a single-byte write.
    function automatic logic [3:0] lane_be(input logic [1:0] lane);
        return 4'b0001 << lane;
    endfunction

endpackage

// File: rtl/avr_xmem_bridge_line.sv
// One-word read line buffer: 32-bit data, word tag and valid flag.
// Supports whole-word fill, single-byte write-through merge, invalidate,
// tag compare and byte select.
module avr_xmem_bridge_line
    import avr_xmem_bridge_pkg::*;
#(
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          fill,
    input  logic [AW-1:0] fill_tag,
    input  logic [31:0]   fill_data,
    input  logic          merge,
    input  logic [1:0]    merge_lane,
    input  logic [7:0]    merge_byte,
    input  logic          inval,
    input  logic [AW-1:0] cmp_tag,
    input  logic [1:0]    rd_lane,
    output logic          hit,
    output logic [7:0]    rd_byte
);

    logic [7:0]    lane_data [4];
    logic [AW-1:0] tag_reg;
    logic          valid_reg;

    // Tag/valid update; invalidate beats a simultaneous fill.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_reg   <= '0;
            valid_reg <= 1'b0;
        end else begin
            if (fill)
                tag_reg <= fill_tag;
            if (inval)
                valid_reg <= 1'b0;
            else if (fill)
                valid_reg <= 1'b1;
        end
    end

    // Per-lane data: fill writes every lane, a merge only the addressed lane of a cached word.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        always_ff @(posedge clk or posedge rst) begin
            if (rst)
                lane_data[gi] <= '0;
            else if (fill)
                lane_data[gi] <= fill_data[gi*8 +: 8];
            else if (merge && hit && (merge_lane == 2'(gi)))
                lane_data[gi] <= merge_byte;
        end
    end

    assign hit     = valid_reg && (tag_reg == cmp_tag);
    assign rd_byte = lane_data[rd_lane];

endmodule

// File: rtl/avr_xmem_bridge.sv
// AVR external-SRAM window slave bridged to a 32-bit req/ack system bus.
// A one-word line buffer serves sequential byte reads with no wait state;
// misses and writes (write-through) go to the bus with a timeout guard.
module avr_xmem_bridge
    import avr_xmem_bridge_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = 16'hE000,
    parameter int          SIZE      = 1024,
    parameter int          TIMEOUT   = 255,
    parameter bit          CACHE_EN  = 1'b1,
    localparam int         AW        = $clog2(SIZE) - 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [15:0]   avr_a,
    input  logic [7:0]    avr_dout,
    output logic [7:0]    avr_din,
    input  logic          avr_cs,
    input  logic          avr_oe,
    input  logic          avr_we,
    output logic          avr_wait,
    output logic          bus_req,
    output logic          bus_we,
    output logic [AW-1:0] bus_addr,
    output logic [3:0]    bus_be,
    output logic [31:0]   bus_wdata,
    input  logic [31:0]   bus_rdata,
    input  logic          bus_ack,
    input  logic          inval,
    input  logic          err_clr,
    output logic          err
);

    state_t        state_reg, state_next;
    logic [15:0]   off;
    logic [AW-1:0] word;
    logic [1:0]    lane;
    logic          unused_off_bits;
    logic          access, rd_access, hit, start, timeout;
    logic          line_hit;
    logic [7:0]    line_byte;
    logic [AW-1:0] cmp_tag;
    logic [7:0]    cnt_reg;
    logic [1:0]    lane_reg;
    logic [7:0]    din_reg;
    logic          err_reg;
    logic          bus_req_reg, bus_we_reg;
    logic [AW-1:0] bus_addr_reg;
    logic [3:0]    bus_be_reg;
    logic [31:0]   bus_wdata_reg;

    // Window offset; addresses outside the window simply wrap.
    assign off             = avr_a - BASE_ADDR;
    assign word            = off[AW+1:2];
    assign lane            = off[1:0];
    assign unused_off_bits = ^off[15:AW+2];

    assign access    = avr_cs && (avr_oe || avr_we);
    assign rd_access = access && !avr_we;
    assign timeout   = (state_reg == ST_REQ) && !bus_ack && (cnt_reg == 8'(TIMEOUT - 1));
    assign cmp_tag   = (state_reg == ST_IDLE) ? word : bus_addr_reg;

    avr_xmem_bridge_line #(.AW(AW)) u_line (
        .clk        (clk),
        .rst        (rst),
        .fill       ((state_reg == ST_REQ) && bus_ack && !bus_we_reg),
        .fill_tag   (bus_addr_reg),
        .fill_data  (bus_rdata),
        .merge      ((state_reg == ST_REQ) && bus_ack && bus_we_reg),
        .merge_lane (lane_reg),
        .merge_byte (bus_wdata_reg[7:0]),
        .inval      (inval),
        .cmp_tag    (cmp_tag),
        .rd_lane    (lane),
        .hit        (line_hit),
        .rd_byte    (line_byte)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_reg <= ST_IDLE;
        else
            state_reg <= state_next;
    end

    // Next-state: a miss or write opens a bus cycle, ack or timeout closes it.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (start) state_next = ST_REQ;
            ST_REQ:  if (bus_ack || timeout) state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // FSM outputs: hit detection, bus start and the combinational AVR stall.
    always_comb begin
        hit      = (state_reg == ST_IDLE) && rd_access && CACHE_EN && line_hit;
        start    = (state_reg == ST_IDLE) && access && !hit;
        avr_wait = !rst && access && !hit && (state_reg != ST_DONE);
    end

    // Bus request registers and timeout counter; outputs frozen while waiting for ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_req_reg   <= 1'b0;
            bus_we_reg    <= 1'b0;
            bus_addr_reg  <= '0;
            bus_be_reg    <= '0;
            bus_wdata_reg <= '0;
            lane_reg      <= '0;
            cnt_reg       <= '0;
        end else begin
            if (start) begin
                bus_req_reg   <= 1'b1;
                bus_we_reg    <= avr_we;
                bus_addr_reg  <= word;
                bus_be_reg    <= avr_we ? lane_be(lane) : BE_ALL;
                bus_wdata_reg <= {4{avr_dout}};
                lane_reg      <= lane;
                cnt_reg       <= '0;
            end else if (state_reg == ST_REQ) begin
                cnt_reg <= cnt_reg + 8'd1;
                if (bus_ack || timeout)
                    bus_req_reg <= 1'b0;
            end
        end
    end

    // Read data holder: updated on a hit, a read completion, or a read timeout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            din_reg <= ERR_RDATA;
        else if (hit)
            din_reg <= line_byte;
        else if ((state_reg == ST_REQ) && bus_ack && !bus_we_reg)
            din_reg <= byte_sel(bus_rdata, lane_reg);
        else if (timeout && !bus_we_reg)
            din_reg <= ERR_RDATA;
    end

    // Sticky error flag; a timeout wins over a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err_reg <= 1'b0;
        else if (timeout)
            err_reg <= 1'b1;
        else if (err_clr)
            err_reg <= 1'b0;
    end

    assign avr_din   = hit ? line_byte : din_reg;
    assign err       = err_reg;
    assign bus_req   = bus_req_reg;
    assign bus_we    = bus_we_reg;
    assign bus_addr  = bus_addr_reg;
    assign bus_be    = bus_be_reg;
    assign bus_wdata = bus_wdata_reg;

endmodule
